// File: rtl/agc_pkg.sv
// Shared types for the AGC hazard/interlock controller: FSM states, the
// in-flight slot record, and the register-match helper.
package agc_pkg;

  localparam int unsigned HZ_NUM_REGS  = 8;
  // Slots store selects at a fixed width so the struct is independent of NUM_REGS.
  localparam int unsigned HZ_SEL_MAX_W = 8;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DRAIN,
    HZ_HALTED
  } hz_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    wr1_en;
    logic [HZ_SEL_MAX_W-1:0] wr1_sel;
    logic                    wr2_en;
    logic [HZ_SEL_MAX_W-1:0] wr2_sel;
  } hz_slot_t;

  // Out-of-range selects name no real register and must never create a hazard.
  function automatic logic hz_match(
    input logic                    src_en,
    input logic [HZ_SEL_MAX_W-1:0] src_sel,
    input logic                    wr_en,
    input logic [HZ_SEL_MAX_W-1:0] wr_sel,
    input int unsigned             num_regs
  );
    return src_en && wr_en && (src_sel == wr_sel) && (32'(src_sel) < num_regs);
  endfunction

endpackage

// File: rtl/agc_slot_pipe.sv
// DEPTH-deep shift register of in-flight writes (slot0 = E, last = W);
// inserts a bubble when nothing is loaded and reports whether any slot is live.
module agc_slot_pipe
  import agc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  hz_slot_t             slot_i,
  output hz_slot_t [DEPTH-1:0] slots_o,
  output logic                 busy_o
);

  hz_slot_t [DEPTH-1:0] slots_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slots_q <= '0;
    end else begin
      slots_q[0] <= load_i ? slot_i : '0;
      for (int k = 1; k < int'(DEPTH); k++) begin
        slots_q[k] <= slots_q[k-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      busy_o = busy_o | slots_q[k].valid;
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/agc_hazard_unit.sv
// Pipeline interlock for the AGC core: RAW stall detection against in-flight
// writes, branch flush, halt/drain/resume FSM and a saturating stall counter.
module agc_hazard_unit
  import agc_pkg::*;
#(
  parameter int unsigned NUM_REGS  = HZ_NUM_REGS,
  parameter int unsigned SEL_W     = $clog2(NUM_REGS),
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             issue_valid_i,
  input  logic             rs1_en_i,
  input  logic             rs2_en_i,
  input  logic [SEL_W-1:0] rs1_sel_i,
  input  logic [SEL_W-1:0] rs2_sel_i,
  input  logic             wr1_en_i,
  input  logic             wr2_en_i,
  input  logic [SEL_W-1:0] wr1_sel_i,
  input  logic [SEL_W-1:0] wr2_sel_i,
  input  logic             branch_E_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             stall_D_o,
  output logic             flush_E_o,
  output logic             halted_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_count_o
);

  // With write-through, the W slot is already visible to the D read.
  localparam int unsigned CHECK_SLOTS = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  hz_state_t               state_q;
  logic [CNT_W-1:0]        stall_count_q;
  hz_slot_t [DEPTH-1:0]    slots;
  hz_slot_t                new_slot;
  logic [DEPTH-1:0]        slot_hit;
  logic [HZ_SEL_MAX_W-1:0] rs1_x, rs2_x;
  logic                    hazard, hz_stall, in_run, accept, busy;

  assign rs1_x = HZ_SEL_MAX_W'(rs1_sel_i);
  assign rs2_x = HZ_SEL_MAX_W'(rs2_sel_i);

  generate
    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_hit
      localparam logic HIT_EN = (gi < int'(CHECK_SLOTS));
      assign slot_hit[gi] = HIT_EN && slots[gi].valid && (
          hz_match(rs1_en_i, rs1_x, slots[gi].wr1_en, slots[gi].wr1_sel, NUM_REGS) ||
          hz_match(rs1_en_i, rs1_x, slots[gi].wr2_en, slots[gi].wr2_sel, NUM_REGS) ||
          hz_match(rs2_en_i, rs2_x, slots[gi].wr1_en, slots[gi].wr1_sel, NUM_REGS) ||
          hz_match(rs2_en_i, rs2_x, slots[gi].wr2_en, slots[gi].wr2_sel, NUM_REGS));
    end
  endgenerate

  assign hazard   = |slot_hit;
  assign in_run   = (state_q == HZ_RUN);
  assign hz_stall = issue_valid_i & hazard & ~branch_E_i;
  assign accept   = issue_valid_i & ~hz_stall & ~branch_E_i & in_run & ~halt_req_i;

  always_comb begin
    new_slot         = '0;
    new_slot.valid   = 1'b1;
    new_slot.wr1_en  = wr1_en_i;
    new_slot.wr1_sel = HZ_SEL_MAX_W'(wr1_sel_i);
    new_slot.wr2_en  = wr2_en_i;
    new_slot.wr2_sel = HZ_SEL_MAX_W'(wr2_sel_i);
  end

  agc_slot_pipe #(.DEPTH(DEPTH)) u_slot_pipe (
    .clk_i   (clock_i),
    .rst_ni  (reset_n_i),
    .load_i  (accept),
    .slot_i  (new_slot),
    .slots_o (slots),
    .busy_o  (busy)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q       <= HZ_RUN;
      stall_count_q <= '0;
    end else begin
      unique case (state_q)
        HZ_RUN:    if (halt_req_i) state_q <= HZ_DRAIN;
        HZ_DRAIN:  if (!busy)      state_q <= HZ_HALTED;
        HZ_HALTED: if (resume_i)   state_q <= HZ_RUN;
        default:                   state_q <= HZ_RUN;
      endcase
      // Only interlock stalls are counted; drain/halt holds are not hazards.
      if (in_run && hz_stall && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_D_o     = hz_stall | ~in_run;
  assign flush_E_o     = branch_E_i;
  assign halted_o      = (state_q == HZ_HALTED);
  assign busy_o        = busy;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_agc_hazard_unit.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the selected instance.
module tb_agc_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       iv, r1e, r2e, w1e, w2e, br, hr, rsm;
  logic [2:0] r1s, r2s, w1s, w2s;

  logic [2:0]  st_w, fl_w, hl_w, bz_w;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  // dut 0: DEPTH=2 bypass; dut 1: DEPTH=3 no bypass; dut 2: DEPTH=2, CNT_W=2
  agc_hazard_unit #(.DEPTH(2), .RF_BYPASS(1), .CNT_W(16)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .issue_valid_i(iv),
    .rs1_en_i(r1e), .rs2_en_i(r2e), .rs1_sel_i(r1s), .rs2_sel_i(r2s),
    .wr1_en_i(w1e), .wr2_en_i(w2e), .wr1_sel_i(w1s), .wr2_sel_i(w2s),
    .branch_E_i(br), .halt_req_i(hr), .resume_i(rsm),
    .stall_D_o(st_w[0]), .flush_E_o(fl_w[0]), .halted_o(hl_w[0]),
    .busy_o(bz_w[0]), .stall_count_o(cnt0));

  agc_hazard_unit #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(16)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .issue_valid_i(iv),
    .rs1_en_i(r1e), .rs2_en_i(r2e), .rs1_sel_i(r1s), .rs2_sel_i(r2s),
    .wr1_en_i(w1e), .wr2_en_i(w2e), .wr1_sel_i(w1s), .wr2_sel_i(w2s),
    .branch_E_i(br), .halt_req_i(hr), .resume_i(rsm),
    .stall_D_o(st_w[1]), .flush_E_o(fl_w[1]), .halted_o(hl_w[1]),
    .busy_o(bz_w[1]), .stall_count_o(cnt1));

  agc_hazard_unit #(.DEPTH(2), .RF_BYPASS(1), .CNT_W(2)) dut2 (
    .clock_i(clk), .reset_n_i(rst_n), .issue_valid_i(iv),
    .rs1_en_i(r1e), .rs2_en_i(r2e), .rs1_sel_i(r1s), .rs2_sel_i(r2s),
    .wr1_en_i(w1e), .wr2_en_i(w2e), .wr1_sel_i(w1s), .wr2_sel_i(w2s),
    .branch_E_i(br), .halt_req_i(hr), .resume_i(rsm),
    .stall_D_o(st_w[2]), .flush_E_o(fl_w[2]), .halted_o(hl_w[2]),
    .busy_o(bz_w[2]), .stall_count_o(cnt2));

  typedef struct {
    string      name;
    int         dut;
    logic [3:0] flags;  // {stall_D, flush_E, halted, busy}
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every expectation pushed during a cycle is checked at its negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [3:0] act_f;
      int         act_c;
      e     = exp_q.pop_front();
      act_f = {st_w[e.dut], fl_w[e.dut], hl_w[e.dut], bz_w[e.dut]};
      act_c = (e.dut == 0) ? int'(cnt0) : (e.dut == 1) ? int'(cnt1) : int'(cnt2);
      checks++;
      if (act_f !== e.flags || act_c != e.cnt) begin
        errors++;
        $display("FAIL %s dut%0d: got {stall,flush,halted,busy}=%b count=%0d, expected %b count=%0d",
                 e.name, e.dut, act_f, act_c, e.flags, e.cnt);
      end else begin
        $display("[%0t] %s dut%0d ok: flags=%b count=%0d", $time, e.name, e.dut, act_f, act_c);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    iv = 0; r1e = 0; r2e = 0; w1e = 0; w2e = 0; br = 0; hr = 0; rsm = 0;
    r1s = 0; r2s = 0; w1s = 0; w2s = 0;
  endtask

  task automatic expect_(input string nm, input int d, input logic st, input logic fl,
                         input logic hl, input logic bz, input int cnt);
    exp_t e;
    e.name = nm; e.dut = d; e.flags = {st, fl, hl, bz}; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] s);
    iv = 1; w1e = 1; w1s = s;
  endtask

  task automatic rd(input logic [2:0] s);
    iv = 1; r1e = 1; r1s = s;
  endtask

  task automatic do_reset();
    next_cycle(); rst_n = 0;
    next_cycle(); rst_n = 1;
  endtask

  localparam logic [2:0] R_A = 3'd0, R_L = 3'd1, R_Q = 3'd2, R_EB = 3'd3,
                         R_Z = 3'd5, R_BB = 3'd6;

  initial begin
    do_reset();
    expect_("reset", 0, 0, 0, 0, 0, 0);
    expect_("reset", 1, 0, 0, 0, 0, 0);
    expect_("reset", 2, 0, 0, 0, 0, 0);

    // DEPTH=2 bypass: write A then read A stalls exactly one cycle
    next_cycle(); wr(R_A);  expect_("s1_wr_a",  0, 0, 0, 0, 0, 0);
    next_cycle(); rd(R_A);  expect_("s1_raw",   0, 1, 0, 0, 1, 0);
    next_cycle(); rd(R_A);  expect_("s1_accept",0, 0, 0, 0, 1, 1);
    next_cycle();           expect_("s1_idle",  0, 0, 0, 0, 1, 1);
    // wr1==wr2 is a single write; hazard seen through rs2
    next_cycle(); iv = 1; w1e = 1; w1s = R_Q; w2e = 1; w2s = R_Q;
                            expect_("s1_dual_wr", 0, 0, 0, 0, 1, 1);
    next_cycle(); iv = 1; r2e = 1; r2s = R_Q;
                            expect_("s1_rs2_raw", 0, 1, 0, 0, 1, 1);
    next_cycle(); iv = 1; r2e = 1; r2s = R_Q;
                            expect_("s1_rs2_go",  0, 0, 0, 0, 1, 2);

    // DEPTH=3 no bypass: three stall cycles, independent read unaffected
    do_reset();
    next_cycle(); wr(R_L);  expect_("s2_wr_l",  1, 0, 0, 0, 0, 0);
    next_cycle(); rd(R_L);  expect_("s2_stall1",1, 1, 0, 0, 1, 0);
    next_cycle(); rd(R_L);  expect_("s2_stall2",1, 1, 0, 0, 1, 1);
    next_cycle(); rd(R_L);  expect_("s2_stall3",1, 1, 0, 0, 1, 2);
    next_cycle(); rd(R_L);  expect_("s2_accept",1, 0, 0, 0, 0, 3);
    next_cycle(); wr(R_L);  expect_("s2_wr_l2", 1, 0, 0, 0, 1, 3);
    next_cycle(); rd(R_Q);  expect_("s2_indep", 1, 0, 0, 0, 1, 3);

    // Hazard and branch together: flush wins, nothing inserted, count unchanged
    do_reset();
    next_cycle(); wr(R_A);          expect_("s3_wr_a",   0, 0, 0, 0, 0, 0);
    next_cycle(); rd(R_A); br = 1;  expect_("s3_flush",  0, 0, 1, 0, 1, 0);
    next_cycle();                   expect_("s3_after1", 0, 0, 0, 0, 1, 0);
    next_cycle();                   expect_("s3_after2", 0, 0, 0, 0, 0, 0);

    // Halt with two writes in flight: drain, halt, resume
    do_reset();
    next_cycle(); wr(R_Z);   expect_("s4_wr_z",    0, 0, 0, 0, 0, 0);
    next_cycle(); wr(R_BB);  expect_("s4_wr_bb",   0, 0, 0, 0, 1, 0);
    next_cycle(); hr = 1;    expect_("s4_halt_req",0, 0, 0, 0, 1, 0);
    next_cycle();            expect_("s4_drain1",  0, 1, 0, 0, 1, 0);
    next_cycle();            expect_("s4_drain2",  0, 1, 0, 0, 0, 0);
    next_cycle();            expect_("s4_halted",  0, 1, 0, 1, 0, 0);
    next_cycle(); rsm = 1;   expect_("s4_resume",  0, 1, 0, 1, 0, 0);
    next_cycle();            expect_("s4_run",     0, 0, 0, 0, 0, 0);
    next_cycle(); rsm = 1;   expect_("s4_stray_rs",0, 0, 0, 0, 0, 0);
    next_cycle();            expect_("s4_still_run",0,0, 0, 0, 0, 0);
    // halt_req with branch: flush this cycle, then drain with nothing accepted
    next_cycle(); wr(R_EB); hr = 1; br = 1;
                             expect_("s4_halt_br", 0, 0, 1, 0, 0, 0);
    next_cycle();            expect_("s4_drain_e", 0, 1, 0, 0, 0, 0);
    next_cycle();            expect_("s4_halted2", 0, 1, 0, 1, 0, 0);

    // Reset asserted during DRAIN
    do_reset();
    next_cycle(); wr(R_A);   expect_("s5_wr_a",    0, 0, 0, 0, 0, 0);
    next_cycle(); rd(R_A);   expect_("s5_raw",     0, 1, 0, 0, 1, 0);
    next_cycle(); rd(R_A);   expect_("s5_accept",  0, 0, 0, 0, 1, 1);
    next_cycle(); hr = 1;    expect_("s5_halt_req",0, 0, 0, 0, 1, 1);
    next_cycle(); rst_n = 0; expect_("s5_drain",   0, 1, 0, 0, 1, 1);
    next_cycle(); rst_n = 1; expect_("s5_post_rst",0, 0, 0, 0, 0, 0);

    // CNT_W=2: five hazard stalls saturate the counter at 3
    do_reset();
    next_cycle(); wr(R_A);   expect_("s6_wr_a", 2, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); rd(R_A); w1e = 1; w1s = R_A;
      expect_($sformatf("s6_chain%0d", i), 2, logic'(i % 2), 0, 0, 1, (i / 2 > 3) ? 3 : i / 2);
    end
    next_cycle();            expect_("s6_sat", 2, 0, 0, 0, 1, 3);

    next_cycle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
